// File: rtl/mem_word_master_if.sv
// Request/response handshake plus memory control/address lines of the
// byte-wide main-memory bus. The bidirectional data byte stays a plain
// inout port on the master so its tristate driver sits at the pin.
interface mem_word_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              mem_cs;
  logic              mem_oe;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_cs, mem_oe, mem_we, mem_addr
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_cs, mem_oe, mem_we, mem_addr
  );
endinterface

// File: rtl/mem_word_master.sv
// Word-to-byte initiator for the main-memory bus. Each accepted 32-bit
// request becomes four byte accesses at base+0..base+3 (little-endian);
// reads are reassembled and returned as one word with a one-cycle pulse.
//
//  state | meaning
//  IDLE  | ready for a request, bus idle, data pins released
//  WRITE | one byte per cycle, cs/we high, byte k driven on data
//  READ  | cs/oe high, each address held RD_WAIT cycles, sample on last
//  DONE  | resp_valid pulse, bus idle (turnaround cycle)
module mem_word_master #(
  parameter int ADDR_W  = 32,
  parameter int RD_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_word_master_if.master   bus,
  inout  wire [7:0]           mem_data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  // Hold counter reload: counts down to zero, sample on the zero cycle.
  localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);

  state_t            state, state_nxt;
  logic [1:0]        k, k_nxt;
  logic [3:0]        wait_cnt, wait_nxt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata_q;
  logic [23:0]       rbuf;
  logic [31:0]       rdata_q;
  logic [7:0]        wbyte;
  logic              in_access;
  logic              data_drive;
  logic              accept;
  logic              rd_sample;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign rd_sample = (state == READ) && (wait_cnt == 4'd0);
  assign in_access = (state == WRITE) || (state == READ);

  // State, byte index and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= 2'd0;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next-state, byte index advance and read hold countdown.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          k_nxt     = 2'd0;
          wait_nxt  = WAIT_LOAD;
          state_nxt = bus.req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        k_nxt = 2'(k + 2'd1);
        if (k == 2'd3) state_nxt = DONE;
      end
      READ: begin
        if (wait_cnt == 4'd0) begin
          k_nxt    = 2'(k + 2'd1);
          wait_nxt = WAIT_LOAD;
          if (k == 2'd3) state_nxt = DONE;
        end else begin
          wait_nxt = 4'(wait_cnt - 4'd1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture at accept and read byte assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base    <= '0;
      wdata_q <= 32'd0;
      rbuf    <= 24'd0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        base    <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (rd_sample) begin
        case (k)
          2'd0: rbuf[7:0]   <= mem_data;
          2'd1: rbuf[15:8]  <= mem_data;
          2'd2: rbuf[23:16] <= mem_data;
          default: rdata_q  <= {mem_data, rbuf};
        endcase
      end
    end
  end

  // Current write byte selected by the byte index.
  always_comb begin
    wbyte = wdata_q[7:0];
    case (k)
      2'd0: wbyte = wdata_q[7:0];
      2'd1: wbyte = wdata_q[15:8];
      2'd2: wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  // Bus outputs decode from state only, so reset idles them immediately.
  assign data_drive     = (state == WRITE);
  assign mem_data       = data_drive ? wbyte : 8'hzz;
  assign bus.mem_cs     = in_access;
  assign bus.mem_we     = (state == WRITE);
  assign bus.mem_oe     = (state == READ);
  assign bus.mem_addr   = in_access ? (base + ADDR_W'(k)) : '0;
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_rdata = rdata_q;

endmodule
